kpn_fifo_channel: RTL

KPN_FIFO_CHANNEL -- requirements
Module: kpn_fifo_channel

---
 rtl/kpn_fifo_channel.sv | 88 ++++++++
 1 files changed

// File: rtl/kpn_fifo_channel.sv
// Synchronous KPN channel FIFO: circular buffer with registered full/empty/count.
// Optional sticky overflow/underflow flags are enabled by defining KPN_FIFO_ERR_FLAGS_EN.
module kpn_fifo_channel #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  rd,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
`ifdef KPN_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [DEPTH_LOG2:0]   count_next;

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  assign rd_accept = rd & ~empty;
  assign wr_accept = wr & (~full | rd_accept);

  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
    count_next = count;
    if (wr_accept && !rd_accept)
      count_next = count + 1'b1;
    else if (rd_accept && !wr_accept)
      count_next = count - 1'b1;
  end

  // NOTE: storage is deliberately not reset; empty gating of rd_accept keeps stale words unreadable.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      data_out <= '0;
    end else begin
      if (wr_accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

`ifdef KPN_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && !wr_accept)
        overflow <= 1'b1;
      if (rd && !rd_accept)
        underflow <= 1'b1;
    end
  end
`endif

endmodule
